// File: rtl/dds_phase_gen_if.sv
// Frequency-tuning-word handshake and waveform-table read bus of dds_phase_gen.
// The slave modport is the generator side and the master modport is the software/table side.
`timescale 1ns/1ps
interface dds_phase_gen_if #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 7
);
  // A word moves on any cycle with ftw_valid && ftw_ready. The producer holds
  // ftw_valid and ftw_in stable until then. ftw_in is ignored while ftw_ready is low.
  logic [ACC_W-1:0]  ftw_in;
  logic              ftw_valid;
  logic              ftw_ready;
  logic [ADDR_W-1:0] ra;
  logic              re;
  logic              sample_valid;
  logic              wrap;

  modport master (
    output ftw_in, ftw_valid,
    input  ftw_ready, ra, re, sample_valid, wrap
  );

  modport slave (
    input  ftw_in, ftw_valid,
    output ftw_ready, ra, re, sample_valid, wrap
  );
endinterface

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator that drives the waveform-table address at a divided sample rate, with a one-deep FTW shadow buffer.
// Optional address dither is enabled by defining DDS_PHASE_DITHER_EN.
`timescale 1ns/1ps
module dds_phase_gen #(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 7,
  parameter int DIV_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             phase_clr,
  dds_phase_gen_if.slave   bus,
  output logic [0:0]       dbg_state_o
);

  localparam logic [0:0] ST_STOP = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0]  shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic              re_q, re_d;
  logic              wrap_q, wrap_d;
  logic              sv_q, sv_d;

  logic              tick;
  logic              xfer;
  logic [ACC_W-1:0]  inc;
  logic [ACC_W:0]    sum;
  logic [ADDR_W-1:0] addr_top;

  always_comb begin
    state_d = en ? ST_RUN : ST_STOP;
    // A phase clear suppresses a tick that falls in the same cycle.
    tick    = (state_d == ST_RUN) && (cnt_q == div) && !phase_clr;
    xfer    = bus.ftw_valid && !pending_q;
    inc     = pending_q ? shadow_q : ftw_act_q;
    sum     = {1'b0, acc_q} + {1'b0, inc};
  end

  // When div drops below the count, no compare matches; the count runs up to all-ones
  // and wraps to zero without emitting a tick.
  always_comb begin
    if ((state_d == ST_STOP) || phase_clr || (cnt_q == div)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    acc_d     = acc_q;
    ra_d      = ra_q;
    ftw_act_d = ftw_act_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    re_d      = tick;
    wrap_d    = tick & sum[ACC_W];
    sv_d      = re_q;
    if (phase_clr) begin
      acc_d = '0;
    end else if (tick) begin
      acc_d = sum[ACC_W-1:0];
    end
    if (tick) begin
      ra_d = addr_top;
    end
    if (xfer) begin
      shadow_d = bus.ftw_in;
    end
    // A transfer and a consuming tick cannot coincide, because ready is low while a word is pending.
    if (pending_q) begin
      if (tick) begin
        ftw_act_d = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      pending_d = xfer;
    end
  end

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITH_W = ((ACC_W - ADDR_W) < 16) ? (ACC_W - ADDR_W) : 16;

  logic [15:0]      lfsr_q, lfsr_d;
  logic [ACC_W-1:0] dither;
  logic [ACC_W-1:0] dith_sum;
  logic             unused_dith_lo;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1. It advances once per sample.
  always_comb begin
    dither               = '0;
    dither[DITH_W-1:0]   = lfsr_q[DITH_W-1:0];
    lfsr_d               = lfsr_q;
    if (tick) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    // Dither affects the address only; acc and wrap remain undithered.
    dith_sum       = sum[ACC_W-1:0] + dither;
    addr_top       = dith_sum[ACC_W-1 -: ADDR_W];
    unused_dith_lo = ^dith_sum[ACC_W-ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign addr_top = sum[ACC_W-1 -: ADDR_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      cnt_q     <= '0;
      acc_q     <= '0;
      ftw_act_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ra_q      <= '0;
      re_q      <= 1'b0;
      wrap_q    <= 1'b0;
      sv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ftw_act_q <= ftw_act_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ra_q      <= ra_d;
      re_q      <= re_d;
      wrap_q    <= wrap_d;
      sv_q      <= sv_d;
    end
  end

  assign bus.ftw_ready    = !pending_q;
  assign bus.ra           = ra_q;
  assign bus.re           = re_q;
  assign bus.wrap         = wrap_q;
  assign bus.sample_valid = sv_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen covering reset, free run, divider, retune,
// phase clear, divider drop, stop/restart and asynchronous reset.
`timescale 1ns/1ps
module tb_dds_phase_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div = 8'd0;
  logic       phase_clr = 1'b0;
  logic [0:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0]  exp_q[$];
  logic [23:0] model_acc;
  logic        model_c;
  int          n;

  typedef struct packed {
    logic        en;
    logic [7:0]  dv;
    logic        clr;
    logic        fv;
    logic [23:0] fin;
    logic        e_re;
    logic [6:0]  e_ra;
    logic        e_wrap;
    logic        e_sv;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[17];

  dds_phase_gen_if #(.ACC_W(24), .ADDR_W(7)) bus ();

  dds_phase_gen #(.ACC_W(24), .ADDR_W(7), .DIV_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .div         (div),
    .phase_clr   (phase_clr),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_n(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ra(input string name, input logic [6:0] exp);
    n_checks++;
`ifdef DDS_PHASE_DITHER_EN
    if (bus.ra !== exp && bus.ra !== 7'(exp + 7'd1)) begin
`else
    if (bus.ra !== exp) begin
`endif
      n_errors++;
      $display("FAIL %s: got ra=%0d expected %0d", name, bus.ra, exp);
    end
  endtask

  initial begin
    bus.ftw_valid = 1'b0;
    bus.ftw_in    = 24'h0;

    //          en    dv     clr   fv    fin           re    ra     wrap  sv    rdy
    vecs[0]  = '{1'b1, 8'd3, 1'b0, 1'b1, 24'h040000,  1'b0, 7'd10, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'd3, 1'b0, 1'b1, 24'h7FFFFF,  1'b0, 7'd10, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd10, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b1, 7'd12, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd12, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd12, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd12, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b1, 7'd14, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd14, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd14, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd14, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'd3, 1'b1, 1'b0, 24'h000000,  1'b0, 7'd14, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd14, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd14, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd14, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b1, 7'd2,  1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 8'd3, 1'b0, 1'b0, 24'h000000,  1'b0, 7'd2,  1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_ra("rst_ra", 7'd0);
    chk1("rst_re", bus.re, 1'b0);
    chk1("rst_wrap", bus.wrap, 1'b0);
    chk1("rst_sv", bus.sample_valid, 1'b0);
    chk1("rst_rdy", bus.ftw_ready, 1'b1);
    rst_n = 1'b1;

    // Load FTW while stopped
    bus.ftw_valid = 1'b1;
    bus.ftw_in    = 24'h020000;
    step();
    chk1("load_rdy", bus.ftw_ready, 1'b0);
    chk1("load_re", bus.re, 1'b0);
    chk1("load_state", dbg_state[0], 1'b0);
    bus.ftw_valid = 1'b0;
    en = 1'b1;

    // Free run, div=0
    model_acc = 24'h0;
    for (int k = 1; k <= 128; k++) begin
      {model_c, model_acc} = {1'b0, model_acc} + {1'b0, 24'h020000};
      exp_q.push_back(model_acc[23:17]);
      step();
      chk1($sformatf("run%0d_re", k), bus.re, 1'b1);
      if (bus.re && exp_q.size() > 0) chk_ra($sformatf("run%0d_ra", k), exp_q.pop_front());
      chk1($sformatf("run%0d_wrap", k), bus.wrap, model_c);
      chk1($sformatf("run%0d_sv", k), bus.sample_valid, k >= 2);
      if (k == 1) chk1("run_rdy_back", bus.ftw_ready, 1'b1);
    end
    chk1("run_state", dbg_state[0], 1'b1);

    // Divider, div=3
    div = 8'd3;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk1($sformatf("div%0d_re", i), bus.re, (i % 4) == 0);
      chk1($sformatf("div%0d_sv", i), bus.sample_valid, (i % 4) == 1);
      chk_ra($sformatf("div%0d_ra", i), 7'(i / 4));
      chk1($sformatf("div%0d_wrap", i), bus.wrap, 1'b0);
    end

    // Retune and phase clear vectors
    for (int i = 0; i < 17; i++) begin
      en            = vecs[i].en;
      div           = vecs[i].dv;
      phase_clr     = vecs[i].clr;
      bus.ftw_valid = vecs[i].fv;
      bus.ftw_in    = vecs[i].fin;
      step();
      chk1($sformatf("v%0d_re", i), bus.re, vecs[i].e_re);
      chk_ra($sformatf("v%0d_ra", i), vecs[i].e_ra);
      chk1($sformatf("v%0d_wrap", i), bus.wrap, vecs[i].e_wrap);
      chk1($sformatf("v%0d_sv", i), bus.sample_valid, vecs[i].e_sv);
      chk1($sformatf("v%0d_rdy", i), bus.ftw_ready, vecs[i].e_rdy);
    end
    phase_clr     = 1'b0;
    bus.ftw_valid = 1'b0;

    // div drops below the count: the count runs out to 255, wraps, then ticks at 1
    step();
    chk1("drop_pre_re", bus.re, 1'b0);
    div = 8'd1;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.re && n < 400);
    chk_n("drop_latency", n, 256);
    chk_ra("drop_ra", 7'd4);

    // Leave RUN right after a tick
    en = 1'b0;
    step();
    chk1("stop_re", bus.re, 1'b0);
    chk1("stop_sv", bus.sample_valid, 1'b1);
    chk_ra("stop_ra", 7'd4);
    chk1("stop_state", dbg_state[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1($sformatf("stop%0d_re", i), bus.re, 1'b0);
      chk1($sformatf("stop%0d_sv", i), bus.sample_valid, 1'b0);
    end

    // A stop in the middle of a count clears the count
    div = 8'd3;
    en  = 1'b1;
    step();
    chk1("rs_a_re", bus.re, 1'b0);
    step();
    chk1("rs_b_re", bus.re, 1'b0);
    en = 1'b0;
    step();
    chk1("rs_c_re", bus.re, 1'b0);
    en = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk1($sformatf("rs%0d_re", j), bus.re, j == 4);
    end
    chk_ra("rs_ra", 7'd6);

    // Asynchronous reset while running with a word pending
    div           = 8'd0;
    bus.ftw_valid = 1'b1;
    bus.ftw_in    = 24'h100000;
    step();
    chk1("pre_rst_re", bus.re, 1'b1);
    chk_ra("pre_rst_ra", 7'd8);
    chk1("pre_rst_rdy", bus.ftw_ready, 1'b0);
    bus.ftw_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_ra("arst_ra", 7'd0);
    chk1("arst_re", bus.re, 1'b0);
    chk1("arst_wrap", bus.wrap, 1'b0);
    chk1("arst_sv", bus.sample_valid, 1'b0);
    chk1("arst_rdy", bus.ftw_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk1("post_rst_re", bus.re, 1'b1);
    chk_ra("post_rst_ra", 7'd0);
    chk1("post_rst_sv", bus.sample_valid, 1'b0);
    chk1("post_rst_rdy", bus.ftw_ready, 1'b1);
    step();
    chk1("post_rst2_re", bus.re, 1'b1);
    chk_ra("post_rst2_ra", 7'd0);
    chk1("post_rst2_sv", bus.sample_valid, 1'b1);

    chk_n("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
